regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter.
// Requester 0 is ALU writeback and requester 1 is load writeback. Contested
// nonzero-rd requests are granted round-robin. A grant appears on the
// registered wb_* port one cycle later. Writes to x0 are accepted and then
// discarded.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] busy,
    output logic        last_grant,
    output logic [15:0] conflict_cnt
);

    localparam logic [0:0] PRI0 = 1'b0;
    localparam logic [0:0] PRI1 = 1'b1;

    logic [0:0]  ptr_q, ptr_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] conflict_q, conflict_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic run;
    logic nz0, nz1;
    logic gnt0, gnt1;

    // Grant decode: x0 requests are always acknowledged but never compete.
    always_comb begin
        run  = rst & ~hold;
        nz0  = req0_valid & (req0_rd != 5'd0);
        nz1  = req1_valid & (req1_rd != 5'd0);
        gnt0 = run & nz0 & (~nz1 | (ptr_q == PRI0));
        gnt1 = run & nz1 & (~nz0 | (ptr_q == PRI1));
        req0_ready = gnt0 | (run & req0_valid & (req0_rd == 5'd0));
        req1_ready = gnt1 | (run & req1_valid & (req1_rd == 5'd0));
    end

    // Next-state logic for the write port, the pointer and the statistics.
    always_comb begin
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        conflict_d   = conflict_q;
        if (gnt0) begin
            wb_we_d      = 1'b1;
            wb_rd_d      = req0_rd;
            wb_data_d    = req0_data;
            ptr_d        = PRI1;
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            wb_we_d      = 1'b1;
            wb_rd_d      = req1_rd;
            wb_data_d    = req1_data;
            ptr_d        = PRI0;
            last_grant_d = 1'b1;
        end
        if (run && nz0 && nz1 && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            ptr_q        <= PRI0;
            last_grant_q <= 1'b0;
            conflict_q   <= '0;
        end else begin
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            conflict_q   <= conflict_d;
        end
    end

    // One-hot busy vector. The x0 bit is masked off even though no x0 write
    // is ever issued.
    always_comb begin
        busy = '0;
        if (wb_we_q) begin
            busy = (32'd1 << wb_rd_q) & ~32'd1;
        end
    end

    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign last_grant   = last_grant_q;
    assign conflict_cnt = conflict_q;

endmodule
